// File: rtl/exec_pkg.sv
// Shared types, field positions and ALU/forwarding helpers for the EX stage.
package exec_pkg;

    localparam int unsigned WIDTH      = 24;
    localparam int unsigned IDX        = 4;
    localparam int unsigned IN_W       = 123;
    localparam int unsigned OUT_W      = 56;
    localparam int unsigned DIV_CYCLES = 24;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned CTRL_W     = 4;
    localparam int unsigned SHAMT_W    = 5;

    // ID/EX bundle field positions
    localparam int unsigned OPCODE_LSB     = 117;  // opType/opCode, not used in EX
    localparam int unsigned IMM_SRC_BIT    = 116;
    localparam int unsigned BRANCH_BIT     = 115;
    localparam int unsigned MEM_WRITE_BIT  = 114;
    localparam int unsigned MEM_TO_REG_BIT = 113;
    localparam int unsigned REG_WRITE_BIT  = 112;
    localparam int unsigned CTRL_LSB       = 108;
    localparam int unsigned RA_LSB         = 104;
    localparam int unsigned RD1_LSB        = 80;
    localparam int unsigned RB_LSB         = 76;
    localparam int unsigned RD2_LSB        = 52;
    localparam int unsigned RC_LSB         = 48;
    localparam int unsigned RD3_LSB        = 24;
    localparam int unsigned IMM_LSB        = 0;

    typedef enum logic [CTRL_W-1:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_MUL = 4'd2,
        ALU_DIV = 4'd3,
        ALU_MOD = 4'd4,
        ALU_AND = 4'd5,
        ALU_OR  = 4'd6,
        ALU_XOR = 4'd7,
        ALU_SLL = 4'd8,
        ALU_SRL = 4'd9,
        ALU_SLT = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // EX/MEM bundle, MSB first
    typedef struct packed {
        logic             reg_write;
        logic             mem_to_reg;
        logic             mem_write;
        logic             branch_taken;
        logic [WIDTH-1:0] alu_result;
        logic [WIDTH-1:0] store_data;
        logic [IDX-1:0]   rc;
    } exmem_t;

    // Single-cycle ALU; DIV/MOD yield 0 here and are handled by the divider when present
    function automatic logic [WIDTH-1:0] alu_calc(input logic [CTRL_W-1:0] ctrl,
                                                  input logic [WIDTH-1:0]  a,
                                                  input logic [WIDTH-1:0]  b);
        logic [WIDTH-1:0] r;
        r = b;
        case (ctrl)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_MUL: r = a * b;
            ALU_DIV: r = '0;
            ALU_MOD: r = '0;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SLL: r = (b[SHAMT_W-1:0] >= SHAMT_W'(WIDTH)) ? '0 : (a << b[SHAMT_W-1:0]);
            ALU_SRL: r = (b[SHAMT_W-1:0] >= SHAMT_W'(WIDTH)) ? '0 : (a >> b[SHAMT_W-1:0]);
            ALU_SLT: r = WIDTH'($signed(a) < $signed(b));
            default: r = b;
        endcase
        return r;
    endfunction

    // Operand bypass: EX/MEM result first, then writeback, never for r0
    function automatic logic [WIDTH-1:0] fwd_sel(input logic [IDX-1:0]   idx,
                                                 input logic [WIDTH-1:0] val,
                                                 input logic             ex_wr,
                                                 input logic [IDX-1:0]   ex_rc,
                                                 input logic [WIDTH-1:0] ex_val,
                                                 input logic             wb_we,
                                                 input logic [IDX-1:0]   wb_rd,
                                                 input logic [WIDTH-1:0] wb_val);
        logic [WIDTH-1:0] r;
        r = val;
        if (idx != '0) begin
            if (ex_wr && (ex_rc == idx)) begin
                r = ex_val;
            end else if (wb_we && (wb_rd == idx)) begin
                r = wb_val;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per step, DIV_CYCLES steps.
// Divide by zero naturally gives quotient all-ones and remainder = dividend.
// Built only when EXEC_DIVIDER_EN is defined.
`ifdef EXEC_DIVIDER_EN
module seq_divider
    import exec_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] rem_next;

    // Shift in the next dividend bit and try the subtraction
    always_comb begin
        trial    = {remainder, quotient[WIDTH-1]};
        fits     = (trial >= {1'b0, dvs_q});
        rem_next = fits ? WIDTH'(trial - {1'b0, dvs_q}) : WIDTH'(trial);
    end

    // Quotient shifts left while the dividend bits are consumed from its top
    always_ff @(posedge clk) begin
        if (rst) begin
            quotient  <= '0;
            remainder <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (start) begin
            quotient  <= dividend;
            remainder <= '0;
            dvs_q     <= divisor;
            cnt_q     <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
        end else if (step && busy) begin
            quotient  <= {quotient[WIDTH-2:0], fits};
            remainder <= rem_next;
            if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
                cnt_q <= '0;
                busy  <= 1'b0;
                done  <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule
`endif

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, ALU, branch compare and the EX/MEM register.
// Define EXEC_DIVIDER_EN to build the multi-cycle divider and its stall FSM;
// otherwise DIV/MOD complete in one cycle with result 0 and stall is tied low.
module execute_stage
    import exec_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [IN_W-1:0]  bufferIn,
    input  logic             WE,
    input  logic [IDX-1:0]   Rd,
    input  logic [WIDTH-1:0] WD,
    output logic             stall,
    output logic [OUT_W-1:0] bufferOut
);

    logic [CTRL_W-1:0] alu_ctrl;
    logic              imm_src;
    logic              branch_flag;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
    logic [IDX-1:0]    ra;
    logic [IDX-1:0]    rb;
    logic [IDX-1:0]    rc;
    logic [WIDTH-1:0]  rd1;
    logic [WIDTH-1:0]  rd2;
    logic [WIDTH-1:0]  rd3;
    logic [WIDTH-1:0]  ext_imm;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]  rd2_fwd;
    logic [WIDTH-1:0]  store_data;
    logic              ex_fwd;
    logic              unused_op;
    exmem_t            issue;
    exmem_t            out_q;
    exmem_t            out_d;

    assign alu_ctrl    = bufferIn[CTRL_LSB +: CTRL_W];
    assign imm_src     = bufferIn[IMM_SRC_BIT];
    assign branch_flag = bufferIn[BRANCH_BIT];
    assign mem_write   = bufferIn[MEM_WRITE_BIT];
    assign mem_to_reg  = bufferIn[MEM_TO_REG_BIT];
    assign reg_write   = bufferIn[REG_WRITE_BIT];
    assign ra          = bufferIn[RA_LSB +: IDX];
    assign rb          = bufferIn[RB_LSB +: IDX];
    assign rc          = bufferIn[RC_LSB +: IDX];
    assign rd1         = bufferIn[RD1_LSB +: WIDTH];
    assign rd2         = bufferIn[RD2_LSB +: WIDTH];
    assign rd3         = bufferIn[RD3_LSB +: WIDTH];
    assign ext_imm     = bufferIn[IMM_LSB +: WIDTH];
    assign unused_op   = ^bufferIn[IN_W-1:OPCODE_LSB];

    // Forward operands and form the single-cycle EX/MEM payload
    always_comb begin
        ex_fwd     = out_q.reg_write & ~out_q.mem_to_reg;
        op_a       = fwd_sel(ra, rd1, ex_fwd, out_q.rc, out_q.alu_result, WE, Rd, WD);
        rd2_fwd    = fwd_sel(rb, rd2, ex_fwd, out_q.rc, out_q.alu_result, WE, Rd, WD);
        store_data = fwd_sel(rc, rd3, ex_fwd, out_q.rc, out_q.alu_result, WE, Rd, WD);
        op_b       = imm_src ? ext_imm : rd2_fwd;

        issue.reg_write    = reg_write;
        issue.mem_to_reg   = mem_to_reg;
        issue.mem_write    = mem_write;
        issue.branch_taken = branch_flag & (store_data == op_a);
        issue.alu_result   = alu_calc(alu_ctrl, op_a, op_b);
        issue.store_data   = store_data;
        issue.rc           = rc;
    end

`ifdef EXEC_DIVIDER_EN
    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    exmem_t            hold_q;
    exmem_t            hold_d;
    logic              mod_q;
    logic              mod_d;
    logic              is_div;
    logic              div_start;
    logic              div_step;
    logic              div_busy;
    logic              div_done;
    logic              unused_div;
    logic [WIDTH-1:0]  quotient;
    logic [WIDTH-1:0]  remainder;

    assign is_div = (alu_ctrl == ALU_DIV) || (alu_ctrl == ALU_MOD);

    seq_divider u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .step      (div_step),
        .dividend  (op_a),
        .divisor   (op_b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // The FSM counter tracks the divider in lockstep, so its status is informational
    assign unused_div = div_busy ^ div_done;

    // Divide sequencing: stall decode, push bubbles, then emit the latched result
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        mod_d     = mod_q;
        out_d     = out_q;
        stall     = 1'b0;
        div_start = 1'b0;
        div_step  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_div) begin
                    stall = en;
                    if (en) begin
                        div_start = 1'b1;
                        hold_d    = issue;
                        mod_d     = (alu_ctrl == ALU_MOD);
                        cnt_d     = '0;
                        out_d     = '0;
                        state_d   = ST_RUN;
                    end
                end else if (en) begin
                    out_d = issue;
                end
            end
            ST_RUN: begin
                stall = 1'b1;
                if (en) begin
                    div_step = 1'b1;
                    out_d    = '0;
                    if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (en) begin
                    out_d            = hold_q;
                    out_d.alu_result = mod_q ? remainder : quotient;
                    state_d          = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Divide FSM state, step counter and latched control fields
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            mod_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            mod_q   <= mod_d;
        end
    end
`else
    assign stall = 1'b0;

    // Every op issues in one cycle when enabled
    always_comb begin
        out_d = out_q;
        if (en) begin
            out_d = issue;
        end
    end
`endif

    // EX/MEM pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bufferOut = out_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage; expectations follow EXEC_DIVIDER_EN.
module tb_execute_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [122:0] bufferIn;
    logic         WE;
    logic [3:0]   Rd;
    logic [23:0]  WD;
    logic         stall;
    logic [55:0]  bufferOut;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [55:0] last_exp    = '0;

`ifdef EXEC_DIVIDER_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    // flag order {immSrc, branchFlag, memWrite, memToReg, regWrite}
    localparam logic [4:0] F_RW  = 5'b00001;
    localparam logic [4:0] F_M2R = 5'b00010;
    localparam logic [4:0] F_MW  = 5'b00100;
    localparam logic [4:0] F_BR  = 5'b01000;
    localparam logic [4:0] F_IMM = 5'b10000;

    execute_stage dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .bufferIn  (bufferIn),
        .WE        (WE),
        .Rd        (Rd),
        .WD        (WD),
        .stall     (stall),
        .bufferOut (bufferOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [55:0] got, input logic [55:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [122:0] mk(input logic [3:0] ctrl, input logic [4:0] fl,
                                        input logic [3:0] ra, input logic [23:0] rd1,
                                        input logic [3:0] rb, input logic [23:0] rd2,
                                        input logic [3:0] rc, input logic [23:0] rd3,
                                        input logic [23:0] imm);
        return {6'b0, fl, ctrl, ra, rd1, rb, rd2, rc, rd3, imm};
    endfunction

    // fl4 = {regWrite, memToReg, memWrite, branchTaken}
    function automatic logic [55:0] ex(input logic [3:0] fl4, input logic [23:0] res,
                                       input logic [23:0] sd, input logic [3:0] rc);
        return {fl4, res, sd, rc};
    endfunction

    task automatic apply(input string tag, input logic [122:0] b, input logic [55:0] want);
        bufferIn = b;
        #1;
        chk({tag, "_stall"}, 56'(stall), 56'(0));
        @(posedge clk);
        #1;
        chk(tag, bufferOut, want);
        last_exp = want;
    endtask

    task automatic run_div(input string tag, input logic [122:0] b, input logic [23:0] res,
                           input logic [3:0] rc, input int pause_at);
        logic [55:0] want;
        int n;
        int cyc;
        int bad;
        want = ex(4'b1000, res, 24'd0, rc);
        n    = 0;
        cyc  = 0;
        bad  = 0;
        bufferIn = b;
        #1;
`ifdef EXEC_DIVIDER_EN
        while (stall === 1'b1 && n < 60) begin
            if (n == pause_at) begin
                en = 1'b0;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                end
                chk({tag, "_pause_stall"}, 56'(stall), 56'(1));
                chk({tag, "_pause_hold"}, bufferOut, '0);
                en = 1'b1;
                #1;
            end
            @(posedge clk);
            #1;
            n++;
            cyc++;
            if (bufferOut !== '0) bad++;
        end
        chk({tag, "_stall_cycles"}, 56'(n), 56'(25));
        chk({tag, "_bubbles"}, 56'(bad), 56'(0));
        chk({tag, "_latency"}, 56'(cyc), 56'((pause_at >= 0) ? 28 : 25));
`else
        chk({tag, "_nostall"}, 56'(stall), 56'(0));
        if (pause_at >= 0) begin
            en = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk({tag, "_en_hold"}, bufferOut, last_exp);
            chk({tag, "_nostall_hold"}, 56'(stall), 56'(0));
            en = 1'b1;
            #1;
        end
`endif
        @(posedge clk);
        #1;
        chk({tag, "_result"}, bufferOut, want);
        last_exp = want;
        bufferIn = '0;
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b1;
        bufferIn = '0;
        WE       = 1'b0;
        Rd       = '0;
        WD       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", bufferOut, '0);
        chk("rst_stall", 56'(stall), 56'(0));
        rst = 1'b0;

        // ALU ops
        apply("add",  mk(4'd0,  F_RW, 4'd1, 24'd5, 4'd2, 24'd7, 4'd3, 24'd0, 24'd0),
                      ex(4'b1000, 24'd12, 24'd0, 4'd3));
        apply("sub",  mk(4'd1,  F_RW, 4'd1, 24'd0, 4'd2, 24'd1, 4'd5, 24'd0, 24'd0),
                      ex(4'b1000, 24'hFFFFFF, 24'd0, 4'd5));
        apply("slt",  mk(4'd10, F_RW, 4'd1, 24'hFFFFFF, 4'd2, 24'd1, 4'd6, 24'd0, 24'd0),
                      ex(4'b1000, 24'd1, 24'd0, 4'd6));
        apply("sll30", mk(4'd8, F_RW | F_IMM, 4'd1, 24'd1, 4'd2, 24'd0, 4'd7, 24'd0, 24'd30),
                      ex(4'b1000, 24'd0, 24'd0, 4'd7));
        apply("srl4", mk(4'd9,  F_RW | F_IMM, 4'd1, 24'h123456, 4'd2, 24'd0, 4'd8, 24'd0, 24'd4),
                      ex(4'b1000, 24'h012345, 24'd0, 4'd8));
        apply("mul",  mk(4'd2,  F_RW, 4'd1, 24'h001234, 4'd2, 24'h000100, 4'd9, 24'd0, 24'd0),
                      ex(4'b1000, 24'h123400, 24'd0, 4'd9));
        apply("and",  mk(4'd5,  F_RW, 4'd1, 24'hF0F0F0, 4'd2, 24'h0FF0FF, 4'd10, 24'd0, 24'd0),
                      ex(4'b1000, 24'h00F0F0, 24'd0, 4'd10));
        apply("xor",  mk(4'd7,  F_RW, 4'd1, 24'hFF00FF, 4'd2, 24'h0F0F0F, 4'd11, 24'd0, 24'd0),
                      ex(4'b1000, 24'hF00FF0, 24'd0, 4'd11));
        apply("or",   mk(4'd6,  F_RW, 4'd1, 24'h100000, 4'd2, 24'h000001, 4'd12, 24'd0, 24'd0),
                      ex(4'b1000, 24'h100001, 24'd0, 4'd12));
        apply("pass", mk(4'd12, F_RW, 4'd1, 24'h0AAAAA, 4'd2, 24'h345678, 4'd13, 24'd0, 24'd0),
                      ex(4'b1000, 24'h345678, 24'd0, 4'd13));
        apply("mulov", mk(4'd2, F_RW, 4'd1, 24'h001000, 4'd2, 24'h001000, 4'd14, 24'd0, 24'd0),
                      ex(4'b1000, 24'd0, 24'd0, 4'd14));

        // Forwarding
        apply("wr_r4", mk(4'd0, F_RW, 4'd1, 24'h10, 4'd2, 24'd0, 4'd4, 24'd0, 24'd0),
                      ex(4'b1000, 24'h10, 24'd0, 4'd4));
        apply("fwd_ex", mk(4'd0, F_RW, 4'd4, 24'd0, 4'd1, 24'd1, 4'd9, 24'd0, 24'd0),
                      ex(4'b1000, 24'h11, 24'd0, 4'd9));
        WE = 1'b1; Rd = 4'd4; WD = 24'h20;
        apply("fwd_wb", mk(4'd0, F_RW, 4'd4, 24'd0, 4'd2, 24'd0, 4'd10, 24'd0, 24'd0),
                      ex(4'b1000, 24'h20, 24'd0, 4'd10));
        WE = 1'b0;
        apply("wr_r0", mk(4'd0, F_RW, 4'd1, 24'h55, 4'd2, 24'd0, 4'd0, 24'd0, 24'd0),
                      ex(4'b1000, 24'h55, 24'd0, 4'd0));
        WE = 1'b1; Rd = 4'd0; WD = 24'h99;
        apply("no_fwd_r0", mk(4'd0, F_RW, 4'd0, 24'd3, 4'd0, 24'd4, 4'd11, 24'h22, 24'd0),
                      ex(4'b1000, 24'd7, 24'h22, 4'd11));
        Rd = 4'd11; WD = 24'h40;
        apply("fwd_prio", mk(4'd0, F_RW, 4'd11, 24'd0, 4'd11, 24'd0, 4'd12, 24'd0, 24'd0),
                      ex(4'b1000, 24'd14, 24'd0, 4'd12));
        WE = 1'b0;
        apply("load", mk(4'd0, F_RW | F_M2R, 4'd1, 24'h30, 4'd2, 24'd0, 4'd13, 24'd0, 24'd0),
                      ex(4'b1100, 24'h30, 24'd0, 4'd13));
        apply("no_fwd_load", mk(4'd0, F_RW, 4'd13, 24'd1, 4'd2, 24'd0, 4'd14, 24'd0, 24'd0),
                      ex(4'b1000, 24'd1, 24'd0, 4'd14));

        // Branch compare
        apply("br_taken", mk(4'd0, F_BR | F_MW, 4'd1, 24'h77, 4'd2, 24'd0, 4'd2, 24'h77, 24'd0),
                      ex(4'b0011, 24'h77, 24'h77, 4'd2));
        apply("br_not", mk(4'd0, F_BR | F_MW, 4'd1, 24'h77, 4'd2, 24'd0, 4'd2, 24'h78, 24'd0),
                      ex(4'b0010, 24'h77, 24'h78, 4'd2));

        // Enable low holds EX/MEM
        en = 1'b0;
        bufferIn = mk(4'd0, F_RW, 4'd1, 24'd9, 4'd2, 24'd9, 4'd1, 24'd0, 24'd0);
        @(posedge clk);
        #1;
        chk("en_hold", bufferOut, last_exp);
        en = 1'b1;
        apply("bubble", '0, '0);

        // Divide and modulo, back to back
        run_div("div", mk(4'd3, F_RW, 4'd1, 24'd100, 4'd2, 24'd7, 4'd5, 24'd0, 24'd0),
                DIV_ON ? 24'd14 : 24'd0, 4'd5, -1);
        run_div("mod", mk(4'd4, F_RW, 4'd1, 24'd100, 4'd2, 24'd7, 4'd6, 24'd0, 24'd0),
                DIV_ON ? 24'd2 : 24'd0, 4'd6, -1);
        run_div("div0", mk(4'd3, F_RW, 4'd1, 24'd100, 4'd2, 24'd0, 4'd7, 24'd0, 24'd0),
                DIV_ON ? 24'hFFFFFF : 24'd0, 4'd7, -1);
        run_div("mod0", mk(4'd4, F_RW, 4'd1, 24'd100, 4'd2, 24'd0, 4'd8, 24'd0, 24'd0),
                DIV_ON ? 24'd100 : 24'd0, 4'd8, -1);
        run_div("div_pause", mk(4'd3, F_RW, 4'd1, 24'd100, 4'd2, 24'd7, 4'd9, 24'd0, 24'd0),
                DIV_ON ? 24'd14 : 24'd0, 4'd9, 5);

        // Reset in the middle of work
`ifdef EXEC_DIVIDER_EN
        bufferIn = mk(4'd3, F_RW, 4'd1, 24'd100, 4'd2, 24'd7, 4'd10, 24'd0, 24'd0);
        repeat (11) @(posedge clk);
        #1;
        chk("mid_run_stall", 56'(stall), 56'(1));
`else
        apply("pre_rst", mk(4'd0, F_RW, 4'd1, 24'd8, 4'd2, 24'd8, 4'd10, 24'd0, 24'd0),
                      ex(4'b1000, 24'd16, 24'd0, 4'd10));
`endif
        rst = 1'b1;
        bufferIn = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_stall", 56'(stall), 56'(0));
        chk("rst_mid_out", bufferOut, '0);
        apply("add_after_rst", mk(4'd0, F_RW, 4'd1, 24'd2, 4'd2, 24'd3, 4'd1, 24'd0, 24'd0),
                      ex(4'b1000, 24'd5, 24'd0, 4'd1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
